// File: rtl/lathe_pkg.sv
// Shared state encoding and timing defaults for the lathe cycle sequencer.
// Tick counts assume a 50 MHz clock; COCOTB_SIM swaps in short values for simulation.
package lathe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SPINUP = 3'd1,
        ST_RUN    = 3'd2,
        ST_COAST  = 3'd3,
        ST_FAULT  = 3'd4
    } lathe_state_e;

`ifdef COCOTB_SIM
    localparam int unsigned LATHE_SPINUP_TICKS = 20;
    localparam int unsigned LATHE_FEED_TICKS   = 40;
    localparam int unsigned LATHE_COAST_TICKS  = 10;
`else
    localparam int unsigned LATHE_SPINUP_TICKS = 150_000_000;
    localparam int unsigned LATHE_FEED_TICKS   = 500_000_000;
    localparam int unsigned LATHE_COAST_TICKS  = 100_000_000;
`endif

    localparam int LATHE_CNT_W = 30;

endpackage

// File: rtl/lathe_delay_timer.sv
// Saturating down-counter: load takes effect on the next edge, done = (count == 0).
// No backpressure; ena low holds the count.
module lathe_delay_timer #(
    parameter int CNT_W = 30
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (ena) begin
            if (load) begin
                count_d = load_val;
            end else if (count_q != '0) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/lathe_cycle_sequencer.sv
// Interlocked spin-up / feed / coast cycle for the lathe; Moore outputs change on the state edge.
// No backpressure; ena low freezes state, timer and edge detector.
module lathe_cycle_sequencer
    import lathe_pkg::*;
#(
    parameter int unsigned SPINUP_TICKS = LATHE_SPINUP_TICKS,
    parameter int unsigned FEED_TICKS   = LATHE_FEED_TICKS,
    parameter int unsigned COAST_TICKS  = LATHE_COAST_TICKS,
    parameter int          CNT_W        = LATHE_CNT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       start,
    input  logic       stop,
    input  logic       estop_n,
    input  logic       guard_closed,
    input  logic       auto_mode,
    input  logic       man_mode,
    output logic       spindle_on,
    output logic       coolant_on,
    output logic       feed_en,
    output logic       busy,
    output logic       fault,
    output logic [2:0] state_o
);

    // A tick count of 0 is treated as 1, i.e. a load value of 0.
    localparam logic [CNT_W-1:0] SPINUP_LD = (SPINUP_TICKS == 0) ? '0 : CNT_W'(SPINUP_TICKS - 1);
    localparam logic [CNT_W-1:0] FEED_LD   = (FEED_TICKS == 0)   ? '0 : CNT_W'(FEED_TICKS - 1);
    localparam logic [CNT_W-1:0] COAST_LD  = (COAST_TICKS == 0)  ? '0 : CNT_W'(COAST_TICKS - 1);

    lathe_state_e     state_q, state_d;
    logic             start_q, start_d;
    logic             armed_q, armed_d;
    logic             auto_q, auto_d;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_done;

    logic start_edge;
    logic auto_v;
    logic man_v;
    logic mode_lost;

    assign start_edge = start & ~start_q;
    assign auto_v     = auto_mode & ~man_mode;
    assign man_v      = man_mode & ~auto_mode;
    assign mode_lost  = ~(auto_v | man_v) | (auto_v != auto_q);

    // armed_q stays low after reset until start is seen low once, so a start
    // held through reset release cannot launch a cycle in either mode.
    always_comb begin
        state_d = state_q;
        start_d = start_q;
        armed_d = armed_q;
        auto_d  = auto_q;
        if (ena) begin
            start_d = start;
            armed_d = armed_q | ~start;
            if (state_q != ST_FAULT && !estop_n) begin
                state_d = ST_FAULT;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (guard_closed && armed_q) begin
                            if (auto_v && start_edge) begin
                                state_d = ST_SPINUP;
                                auto_d  = 1'b1;
                            end else if (man_v && start) begin
                                state_d = ST_RUN;
                                auto_d  = 1'b0;
                            end
                        end
                    end
                    ST_SPINUP, ST_RUN: begin
                        if (!guard_closed) begin
                            state_d = ST_FAULT;
                        end else if (stop || mode_lost) begin
                            state_d = ST_COAST;
                        end else if (state_q == ST_SPINUP) begin
                            if (tmr_done) state_d = ST_RUN;
                        end else if (auto_q ? tmr_done : !start) begin
                            state_d = ST_COAST;
                        end
                    end
                    ST_COAST: begin
                        if (tmr_done) state_d = ST_IDLE;
                    end
                    ST_FAULT: begin
                        if (tmr_done && estop_n && !start) state_d = ST_IDLE;
                    end
                    default: state_d = ST_FAULT;
                endcase
            end
        end
    end

    always_comb begin
        tmr_load = (state_d != state_q);
        tmr_val  = '0;
        case (state_d)
            ST_SPINUP:          tmr_val = SPINUP_LD;
            ST_RUN:             tmr_val = FEED_LD;
            ST_COAST, ST_FAULT: tmr_val = COAST_LD;
            default:            tmr_val = '0;
        endcase
    end

    lathe_delay_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            start_q <= 1'b0;
            armed_q <= 1'b0;
            auto_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            armed_q <= armed_d;
            auto_q  <= auto_d;
        end
    end

    always_comb begin
        spindle_on = 1'b0;
        coolant_on = 1'b0;
        feed_en    = 1'b0;
        busy       = (state_q != ST_IDLE);
        fault      = (state_q == ST_FAULT);
        state_o    = state_q;
        case (state_q)
            ST_SPINUP: spindle_on = 1'b1;
            ST_RUN: begin
                spindle_on = 1'b1;
                coolant_on = 1'b1;
                feed_en    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lathe_cycle_sequencer.sv
// Directed and random stimulus for lathe_cycle_sequencer against a cycle-level phase model.
module tb_lathe_cycle_sequencer;

    localparam int T_SPIN  = 20;
    localparam int T_FEED  = 40;
    localparam int T_COAST = 10;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       start;
    logic       stop;
    logic       estop_n;
    logic       guard_closed;
    logic       auto_mode;
    logic       man_mode;
    logic       spindle_on;
    logic       coolant_on;
    logic       feed_en;
    logic       busy;
    logic       fault;
    logic [2:0] state_o;

    int vectors     = 0;
    int miscompares = 0;

    // Model: current phase, cycles already spent in it, mode of the running cycle.
    int m_ph;
    int m_elapsed;
    bit m_auto;
    bit m_prev_start;
    bit m_armed;

    lathe_cycle_sequencer #(
        .SPINUP_TICKS (T_SPIN),
        .FEED_TICKS   (T_FEED),
        .COAST_TICKS  (T_COAST),
        .CNT_W        (30)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .start        (start),
        .stop         (stop),
        .estop_n      (estop_n),
        .guard_closed (guard_closed),
        .auto_mode    (auto_mode),
        .man_mode     (man_mode),
        .spindle_on   (spindle_on),
        .coolant_on   (coolant_on),
        .feed_en      (feed_en),
        .busy         (busy),
        .fault        (fault),
        .state_o      (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] obs_vec();
        return {state_o, spindle_on, coolant_on, feed_en, busy, fault};
    endfunction

    function automatic logic [7:0] exp_vec(input int ph);
        logic [2:0] s;
        s = 3'(ph);
        return {s, (ph == 1 || ph == 2), (ph == 2), (ph == 2), (ph != 0), (ph == 4)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ph         = 0;
        m_elapsed    = 0;
        m_auto       = 1'b0;
        m_prev_start = 1'b0;
        m_armed      = 1'b0;
    endtask

    // Phase lengths in cycles; the last cycle of a phase is elapsed == len-1.
    function automatic bit dwell_over(input int len);
        return (m_elapsed + 1) >= len;
    endfunction

    task automatic model_update();
        int  nxt;
        bit  av, mv, edge_s;
        av     = auto_mode && !man_mode;
        mv     = man_mode && !auto_mode;
        edge_s = start && !m_prev_start;
        nxt    = m_ph;
        if (m_ph != 4 && !estop_n) begin
            nxt = 4;
        end else if (m_ph == 4) begin
            if (dwell_over(T_COAST) && estop_n && !start) nxt = 0;
        end else if ((m_ph == 1 || m_ph == 2) && !guard_closed) begin
            nxt = 4;
        end else if ((m_ph == 1 || m_ph == 2) && (stop || !(av || mv) || av != m_auto)) begin
            nxt = 3;
        end else if (m_ph == 0) begin
            if (guard_closed && m_armed && av && edge_s) begin
                nxt = 1; m_auto = 1'b1;
            end else if (guard_closed && m_armed && mv && start) begin
                nxt = 2; m_auto = 1'b0;
            end
        end else if (m_ph == 1) begin
            if (dwell_over(T_SPIN)) nxt = 2;
        end else if (m_ph == 2) begin
            if (m_auto ? dwell_over(T_FEED) : !start) nxt = 3;
        end else if (m_ph == 3) begin
            if (dwell_over(T_COAST)) nxt = 0;
        end
        if (!start) m_armed = 1'b1;
        m_prev_start = start;
        m_elapsed    = (nxt != m_ph) ? 0 : m_elapsed + 1;
        m_ph         = nxt;
    endtask

    task automatic step(input string tag);
        if (rst_n && ena) model_update();
        @(posedge clk);
        #1;
        check(tag, 32'(obs_vec()), 32'(exp_vec(m_ph)));
    endtask

    task automatic steps(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    initial begin
        int n_spin, n_feed, n_coast;

        rst_n = 1'b0; ena = 1'b1; start = 1'b0; stop = 1'b0; estop_n = 1'b1;
        guard_closed = 1'b1; auto_mode = 1'b1; man_mode = 1'b0;
        model_reset();
        #1;
        check("reset_outputs", 32'(obs_vec()), 32'h0);
        steps(2, "in_reset");
        rst_n = 1'b1;
        steps(3, "idle_after_reset");

        // 1. AUTO cycle from a one-clock start pulse
        n_spin = 0; n_feed = 0; n_coast = 0;
        start = 1'b1;
        for (int i = 0; i < 80; i++) begin
            step("auto_cycle");
            start = 1'b0;
            if (spindle_on && !feed_en) n_spin++;
            if (feed_en && spindle_on && coolant_on) n_feed++;
            if (busy && !spindle_on && !fault) n_coast++;
        end
        check("auto_spinup_len", n_spin, T_SPIN);
        check("auto_feed_len", n_feed, T_FEED);
        check("auto_coast_len", n_coast, T_COAST);
        check("auto_end_idle", 32'(state_o), 0);

        // 2. MAN, start held 15 clocks
        auto_mode = 1'b0; man_mode = 1'b1;
        start = 1'b1;
        step("man_rise");
        check("man_run_after_rise", 32'(state_o), 2);
        steps(14, "man_hold");
        start = 1'b0;
        step("man_fall");
        check("man_coast_after_fall", 32'(state_o), 3);
        steps(10, "man_coast");
        check("man_idle", 32'(state_o), 0);

        // 3. estop during AUTO RUN, release after 3 clocks
        auto_mode = 1'b1; man_mode = 1'b0;
        start = 1'b1; step("est_start"); start = 1'b0;
        steps(T_SPIN + 4, "est_to_run5");
        estop_n = 1'b0;
        step("est_trip");
        check("est_fault_vec", 32'(obs_vec()), 32'({3'd4, 5'b00011}));
        steps(2, "est_hold");
        estop_n = 1'b1;
        steps(7, "est_released");
        check("est_still_fault", 32'(state_o), 4);
        step("est_exit");
        check("est_idle_after_10", 32'(state_o), 0);

        // 4. guard open and stop together during SPINUP
        start = 1'b1; step("g_start"); start = 1'b0;
        steps(3, "g_spin");
        guard_closed = 1'b0; stop = 1'b1;
        step("g_and_stop");
        check("guard_beats_stop", 32'(state_o), 4);
        guard_closed = 1'b1; stop = 1'b0;
        steps(12, "g_recover");

        // 5. both selectors: no start; then mode change mid-RUN
        man_mode = 1'b1;
        start = 1'b1; step("both_edge"); start = 1'b0;
        check("both_busy", 32'(busy), 0);
        steps(2, "both_idle");
        man_mode = 1'b0;
        start = 1'b1; step("mc_start"); start = 1'b0;
        steps(T_SPIN + 3, "mc_run");
        auto_mode = 1'b0; man_mode = 1'b1;
        step("mc_switch");
        check("mode_change_coast", 32'(state_o), 3);
        auto_mode = 1'b1; man_mode = 1'b0;
        steps(12, "mc_recover");

        // ena freeze mid-SPINUP
        start = 1'b1; step("ena_start"); start = 1'b0;
        steps(5, "ena_spin");
        ena = 1'b0;
        steps(30, "ena_frozen");
        check("ena_holds_spinup", 32'(state_o), 1);
        ena = 1'b1;
        steps(80, "ena_resume");

        // 6. async reset during RUN, start held through release
        start = 1'b1; step("rst_start");
        steps(T_SPIN + 2, "rst_run");
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'(obs_vec()), 32'h0);
        model_reset();
        steps(2, "rst_low");
        rst_n = 1'b1;
        steps(5, "rst_start_held");
        check("no_restart_held", 32'(state_o), 0);
        start = 1'b0; step("rst_toggle_lo");
        start = 1'b1; step("rst_toggle_hi");
        check("restart_after_toggle", 32'(state_o), 1);
        start = 1'b0;
        steps(75, "rst_finish");

        // Randomised operation
        for (int i = 0; i < 4000; i++) begin
            estop_n      = ($urandom_range(0, 199) != 0);
            guard_closed = ($urandom_range(0, 149) != 0);
            stop         = ($urandom_range(0, 99) < 2);
            ena          = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 9) == 0) start = ~start;
            if ($urandom_range(0, 149) == 0) begin
                auto_mode = 1'($urandom_range(0, 1));
                man_mode  = 1'($urandom_range(0, 1));
            end
            step("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
